// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Includes the leading-zero blank-mask helper used on the result path.
package bin2bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_BIN_W  = 32;
  localparam int DEF_DIGITS = 10;
  localparam int CNT_W      = $clog2(DEF_BIN_W);

  // Helper works on a fixed wide vector; callers zero-extend and truncate.
  localparam int MAX_DIGITS = 20;

  function automatic logic [MAX_DIGITS-1:0] blank_mask(input logic [4*MAX_DIGITS-1:0] bcd);
    logic [MAX_DIGITS-1:0] m;
    logic                  all_zero;
    all_zero = 1'b1;
    m        = '0;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (bcd[4*i +: 4] == 4'd0);
      m[i]     = all_zero;
    end
    return m;
  endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Producer/consumer bundle for the converter: input handshake plus result bus.
// Handshake: a word transfers on a clock edge where in_valid and in_ready are both 1;
// out_valid is a one-cycle strobe marking that bcd_out/blank were just updated.
interface bin2bcd_if #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin_in;
  logic                  out_valid;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [DIGITS-1:0]     blank;
  logic                  busy;

  modport master (
    output in_valid, bin_in,
    input  in_ready, out_valid, bcd_out, blank, busy
  );

  modport slave (
    input  in_valid, bin_in,
    output in_ready, out_valid, bcd_out, blank, busy
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to 10-digit BCD converter (shift-and-add-3), one bit per clock.
// Result and blank mask are held until the next conversion completes.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic       clk,
  input  logic       rst_n,
  bin2bcd_if.slave   bus,
  output state_t     state_dbg
);

  localparam int CW = $clog2(BIN_W);
  localparam int WW = 4 * DIGITS + BIN_W;

  state_t              state;
  state_t              state_next;
  logic [CW-1:0]       cnt;
  logic                last;
  logic [WW-1:0]       work;
  logic [WW-1:0]       work_next;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] bcd_next;
  logic [DIGITS-1:0]   blank_next;
  logic                out_valid_q;
  logic [4*DIGITS-1:0] bcd_out_q;
  logic [DIGITS-1:0]   blank_q;

  // work holds {bcd digits, remaining binary bits}; digits are corrected, then the pair shifts.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (work[BIN_W + 4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  assign work_next  = {adj, work[BIN_W-1:0]} << 1;
  assign bcd_next   = work_next[WW-1:BIN_W];
  assign blank_next = DIGITS'(blank_mask((4*MAX_DIGITS)'(bcd_next)));
  assign last       = (cnt == CW'(BIN_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = SHIFT;
      SHIFT:   if (last)         state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == IDLE);
    bus.busy     = (state == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work        <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      bcd_out_q   <= '0;
      blank_q     <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work <= {{(4*DIGITS){1'b0}}, bus.bin_in};
            cnt  <= '0;
          end
        end
        SHIFT: begin
          work <= work_next;
          cnt  <= cnt + 1'b1;
          if (last) begin
            bcd_out_q   <= bcd_next;
            blank_q     <= blank_next;
            out_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.bcd_out   = bcd_out_q;
  assign bus.blank     = blank_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: decimal-arithmetic reference model compared every cycle,
// plus directed conversions pinned to hand-computed BCD/blank literals.
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

  localparam int BW = 32;
  localparam int DG = 10;
  localparam logic [DG-1:0] RST_BLANK = {{(DG-1){1'b1}}, 1'b0};

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  state_t state_dbg;

  bin2bcd_if #(.BIN_W(BW), .DIGITS(DG)) bus ();

  bin2bcd_seq #(.BIN_W(BW), .DIGITS(DG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: plain decimal arithmetic
  function automatic logic [4*DG-1:0] to_bcd(input logic [BW-1:0] v);
    longint unsigned x;
    logic [4*DG-1:0] r;
    x = 64'(v);
    r = '0;
    for (int i = 0; i < DG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [DG-1:0] model_blank(input logic [4*DG-1:0] b);
    int top;
    logic [DG-1:0] m;
    top = 0;
    for (int i = 0; i < DG; i++) if (b[4*i +: 4] != 4'd0) top = i;
    for (int i = 0; i < DG; i++) m[i] = (i > top);
    return m;
  endfunction

  logic            m_busy = 1'b0;
  int              m_cnt  = 0;
  logic            m_ov   = 1'b0;
  logic [4*DG-1:0] m_bcd  = '0;
  logic [4*DG-1:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_ov   <= 1'b0;
      m_bcd  <= '0;
      exp_q.delete();
    end else begin
      m_ov <= 1'b0;
      if (!m_busy) begin
        if (bus.in_valid) begin
          m_busy <= 1'b1;
          m_cnt  <= BW;
          exp_q.push_back(to_bcd(bus.bin_in));
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_ov   <= 1'b1;
          m_bcd  <= exp_q.pop_front();
        end
      end
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    check("in_ready",  64'(bus.in_ready),  64'(!m_busy));
    check("busy",      64'(bus.busy),      64'(m_busy));
    check("out_valid", 64'(bus.out_valid), 64'(m_ov));
    check("bcd_out",   64'(bus.bcd_out),   64'(m_bcd));
    check("blank",     64'(bus.blank),     64'(model_blank(m_bcd)));
  end

  // driver tasks
  task automatic wait_ov(input int limit, output int k);
    k = 0;
    while (k < limit) begin
      @(negedge clk);
      k++;
      if (bus.out_valid) return;
    end
    k = -1;
  endtask

  task automatic run_lit(input logic [BW-1:0] v, input logic [4*DG-1:0] eb,
                         input logic [DG-1:0] ebl, input string tag);
    int k;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bin_in   = v;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.bin_in   = $urandom;
    wait_ov(40, k);
    check({tag, "_latency"}, 64'(k), 64'd32);
    check({tag, "_bcd"},     64'(bus.bcd_out), 64'(eb));
    check({tag, "_blank"},   64'(bus.blank),   64'(ebl));
    @(negedge clk);
    check({tag, "_pulse"},   64'(bus.out_valid), 64'd0);
  endtask

  int              b2b_vals[3]  = '{9, 10, 1000000000};
  logic [4*DG-1:0] b2b_bcd[3]   = '{40'h0000000009, 40'h0000000010, 40'h1000000000};
  logic [DG-1:0]   b2b_blank[3] = '{10'b1111111110, 10'b1111111100, 10'b0000000000};
  int              t_out[3];
  logic [4*DG-1:0] got_bcd[3];
  logic [DG-1:0]   got_blank[3];
  logic [BW-1:0]   pow10[10] = '{1, 10, 100, 1000, 10000, 100000, 1000000,
                                 10000000, 100000000, 1000000000};

  initial begin
    int k;
    int ni;
    int no;
    bus.in_valid = 1'b0;
    bus.bin_in   = '0;
    repeat (3) @(negedge clk);
    check("rst_bcd",   64'(bus.bcd_out),   64'd0);
    check("rst_blank", 64'(bus.blank),     64'(RST_BLANK));
    check("rst_ready", 64'(bus.in_ready),  64'd1);
    check("rst_busy",  64'(bus.busy),      64'd0);
    check("rst_ov",    64'(bus.out_valid), 64'd0);
    check("rst_state", 64'(state_dbg),     64'(IDLE));
    rst_n = 1'b1;

    run_lit(32'd0,        40'h0000000000, 10'b1111111110, "zero");
    run_lit(32'd12345,    40'h0000012345, 10'b1111100000, "v12345");
    run_lit(32'hFFFFFFFF, 40'h4294967295, 10'b0000000000, "max");

    // back-to-back with in_valid held high; garbage presented while busy
    ni = 0;
    no = 0;
    for (int c = 0; c < 150 && no < 3; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        t_out[no]     = cyc;
        got_bcd[no]   = bus.bcd_out;
        got_blank[no] = bus.blank;
        no++;
      end
      if (ni < 3) begin
        bus.in_valid = 1'b1;
        if (bus.in_ready) begin
          bus.bin_in = b2b_vals[ni];
          ni++;
        end else begin
          bus.bin_in = $urandom;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    check("b2b_count", 64'(no), 64'd3);
    if (no == 3) begin
      check("b2b_gap01", 64'(t_out[1] - t_out[0]), 64'd33);
      check("b2b_gap12", 64'(t_out[2] - t_out[1]), 64'd33);
      for (int i = 0; i < 3; i++) begin
        check("b2b_bcd",   64'(got_bcd[i]),   64'(b2b_bcd[i]));
        check("b2b_blank", 64'(got_blank[i]), 64'(b2b_blank[i]));
      end
    end

    // in_valid pulse with 55 while busy must be ignored
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bin_in   = 32'd4096;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bin_in   = 32'd55;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_ov(40, k);
    check("busy55_latency", 64'(k), 64'd21);
    check("busy55_bcd",     64'(bus.bcd_out), 64'h0000004096);
    check("busy55_blank",   64'(bus.blank),   64'(10'b1111110000));

    // asynchronous reset at shift 15 of 987654321
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bin_in   = 32'd987654321;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_bcd",   64'(bus.bcd_out),   64'd0);
    check("arst_blank", 64'(bus.blank),     64'(RST_BLANK));
    check("arst_ov",    64'(bus.out_valid), 64'd0);
    check("arst_ready", 64'(bus.in_ready),  64'd1);
    check("arst_busy",  64'(bus.busy),      64'd0);
    check("arst_state", 64'(state_dbg),     64'(IDLE));
    bus.in_valid = 1'b1;
    bus.bin_in   = 32'd7;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_ov(40, k);
    check("post_rst_latency", 64'(k), 64'd32);
    check("post_rst_bcd",     64'(bus.bcd_out), 64'h0000000007);
    check("post_rst_blank",   64'(bus.blank),   64'(10'b1111111110));

    // randomized conversions with garbage in_valid traffic while busy
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.in_valid = 1'b1;
      case ($urandom_range(0, 3))
        0:       bus.bin_in = $urandom;
        1:       bus.bin_in = $urandom_range(0, 99);
        2:       bus.bin_in = 32'hFFFFFFFF - $urandom_range(0, 5);
        default: bus.bin_in = pow10[$urandom_range(0, 9)] - $urandom_range(0, 1);
      endcase
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (bus.out_valid) break;
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.bin_in   = $urandom;
      end
      bus.in_valid = 1'b0;
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
